// File: rtl/seq_pkg.sv
// Shared types, tempo constants and width helpers for the drum step sequencer.
package seq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_e;

    localparam int              DEF_NUM_CH         = 4;
    localparam int              DEF_NUM_STEPS      = 8;
    localparam longint unsigned DEF_CLK_HZ         = 64'd50_000_000;
    localparam int              DEF_STEPS_PER_BEAT = 2;
    localparam int              DEF_BPM_W          = 8;
    localparam int              DEF_BPM            = 120;

    // Clock cycles per minute: one step fires each time the phase passes this.
    function automatic longint unsigned acc_lim(input longint unsigned clk_hz);
        return clk_hz * 64'd60;
    endfunction

    function automatic longint unsigned max_inc(input int bpm_w, input int steps_per_beat);
        return ((64'd1 << bpm_w) - 64'd1) * longint'(steps_per_beat);
    endfunction

    // Select width for an index over n entries, never narrower than one bit.
    function automatic int index_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int acc_w(input longint unsigned lim, input longint unsigned inc_max);
        return $clog2(lim + inc_max);
    endfunction

    localparam int CH_W  = index_w(DEF_NUM_CH);
    localparam int ST_W  = index_w(DEF_NUM_STEPS);
    localparam int ACC_W = acc_w(acc_lim(DEF_CLK_HZ), max_inc(DEF_BPM_W, DEF_STEPS_PER_BEAT));

endpackage

// File: rtl/step_sequencer_if.sv
// Control, pattern-write and display/trigger bundle of the step sequencer.
interface step_sequencer_if #(
    parameter int NUM_CH    = 4,
    parameter int NUM_STEPS = 8,
    parameter int BPM_W     = 8
);
    import seq_pkg::*;

    localparam int CH_BITS = index_w(NUM_CH);
    localparam int ST_BITS = index_w(NUM_STEPS);

    logic [BPM_W-1:0]   bpm;
    logic               bpm_load;
    logic               start;
    logic               stop;
    logic               wr_en;
    logic [CH_BITS-1:0] wr_ch;
    logic [ST_BITS-1:0] wr_step;
    logic               wr_val;
    logic [ST_BITS-1:0] loop_len;
    logic [NUM_CH-1:0]  mute;
    logic [NUM_CH-1:0]  trig;
    logic [ST_BITS-1:0] step_idx;
    logic               step_tick;
    logic               playing;
    logic [NUM_CH-1:0]  cur_col;

    modport master (
        output bpm, bpm_load, start, stop, wr_en, wr_ch, wr_step, wr_val, loop_len, mute,
        input  trig, step_idx, step_tick, playing, cur_col
    );

    modport slave (
        input  bpm, bpm_load, start, stop, wr_en, wr_ch, wr_step, wr_val, loop_len, mute,
        output trig, step_idx, step_tick, playing, cur_col
    );

endinterface

// File: rtl/step_tick_gen.sv
// Exact phase accumulator: adds inc every running cycle and fires on each wrap past ACC_LIM.
module step_tick_gen #(
    parameter int              ACC_W   = 13,
    parameter longint unsigned ACC_LIM = 64'd6000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             clear,
    input  logic [ACC_W-1:0] inc,
    output logic             fire
);
    localparam logic [ACC_W:0] LIM = (ACC_W + 1)'(ACC_LIM);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W:0]   sum;

    // The remainder is carried over on a fire, so tempo is exact without a divider.
    always_comb begin
        sum   = {1'b0, acc_q} + {1'b0, inc};
        fire  = 1'b0;
        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (run) begin
            if (sum >= LIM) begin
                fire  = 1'b1;
                acc_d = ACC_W'(sum - LIM);
            end else begin
                acc_d = sum[ACC_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/step_sequencer.sv
// N-channel, M-step drum pattern sequencer: pattern grid, play/idle control and
// step counter; step timing comes from step_tick_gen.
module step_sequencer
    import seq_pkg::*;
#(
    parameter int              NUM_CH         = DEF_NUM_CH,
    parameter int              NUM_STEPS      = DEF_NUM_STEPS,
    parameter longint unsigned CLK_HZ         = DEF_CLK_HZ,
    parameter int              STEPS_PER_BEAT = DEF_STEPS_PER_BEAT,
    parameter int              BPM_W          = DEF_BPM_W,
    parameter int              DEFAULT_BPM    = DEF_BPM
) (
    input  logic            clk,
    input  logic            reset,
    step_sequencer_if.slave bus
);
    localparam int              CH_BITS  = index_w(NUM_CH);
    localparam int              ST_BITS  = index_w(NUM_STEPS);
    localparam longint unsigned ACC_LIM  = acc_lim(CLK_HZ);
    localparam longint unsigned MAX_INC  = max_inc(BPM_W, STEPS_PER_BEAT);
    localparam int              ACC_BITS = acc_w(ACC_LIM, MAX_INC);

    if (MAX_INC >= ACC_LIM) begin : g_inc_check
        $error("step_sequencer: maximum tempo increment must stay below CLK_HZ*60");
    end

    state_e              state_q;
    logic [ST_BITS-1:0]  step_q;
    logic [NUM_CH-1:0]   trig_q;
    logic                tick_q;
    logic [BPM_W-1:0]    active_bpm_q;
    logic [NUM_STEPS-1:0] pat_q [NUM_CH];

    logic [ST_BITS-1:0]  eff_len_d;
    logic [ST_BITS-1:0]  next_step_d;
    logic [NUM_CH-1:0]   col_cur;
    logic [NUM_CH-1:0]   col_next;
    logic [NUM_CH-1:0]   col_first;
    logic [ACC_BITS-1:0] inc;
    logic                fire;

    assign inc = ACC_BITS'(active_bpm_q) * ACC_BITS'(STEPS_PER_BEAT);

    step_tick_gen #(
        .ACC_W   (ACC_BITS),
        .ACC_LIM (ACC_LIM)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .run   (state_q == PLAY),
        .clear (bus.start | bus.stop),
        .inc   (inc),
        .fire  (fire)
    );

    // A loop length beyond the grid is clamped to the last stored step.
    always_comb begin
        if ({1'b0, bus.loop_len} > (ST_BITS + 1)'(NUM_STEPS - 1)) begin
            eff_len_d = ST_BITS'(NUM_STEPS - 1);
        end else begin
            eff_len_d = bus.loop_len;
        end
        next_step_d = (step_q >= eff_len_d) ? '0 : step_q + ST_BITS'(1);
        col_cur     = '0;
        col_next    = '0;
        col_first   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            col_cur[c]   = pat_q[c][step_q];
            col_next[c]  = pat_q[c][next_step_d];
            col_first[c] = pat_q[c][0];
        end
    end

    // Only encodable in-range (channel, step) pairs match, so stray addresses write nothing.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                pat_q[c] <= '0;
            end
        end else if (bus.wr_en) begin
            for (int c = 0; c < NUM_CH; c++) begin
                for (int s = 0; s < NUM_STEPS; s++) begin
                    if (bus.wr_ch == CH_BITS'(c) && bus.wr_step == ST_BITS'(s)) begin
                        pat_q[c][s] <= bus.wr_val;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            step_q       <= '0;
            trig_q       <= '0;
            tick_q       <= 1'b0;
            active_bpm_q <= BPM_W'(DEFAULT_BPM);
        end else begin
            if (bus.bpm_load) begin
                active_bpm_q <= bus.bpm;
            end
            trig_q <= '0;
            tick_q <= 1'b0;
            if (bus.stop) begin
                state_q <= IDLE;
                step_q  <= '0;
            end else if (bus.start) begin
                state_q <= PLAY;
                step_q  <= '0;
                tick_q  <= 1'b1;
                trig_q  <= col_first & ~bus.mute;
            end else if (fire) begin
                step_q <= next_step_d;
                tick_q <= 1'b1;
                trig_q <= col_next & ~bus.mute;
            end
        end
    end

    assign bus.trig      = trig_q;
    assign bus.step_idx  = step_q;
    assign bus.step_tick = tick_q;
    assign bus.playing   = (state_q == PLAY);
    assign bus.cur_col   = col_cur;

endmodule

// File: tb/tb_step_sequencer.sv
// Randomised and directed bench for step_sequencer with a queue-based scoreboard
// fed by a step-level reference model.
module tb_step_sequencer;
    localparam int NCH = 4;
    localparam int NST = 8;
    localparam int SPB = 1;
    localparam longint LIM = 100 * 60;

    typedef struct {
        int             cyc;
        int             step;
        logic [NCH-1:0] trig;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    bit     m_pat [NCH][NST];
    int     m_step;
    int     m_bpm;
    longint m_acc;
    bit     m_playing;
    exp_t   sb_q[$];
    exp_t   mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    step_sequencer_if #(.NUM_CH(4), .NUM_STEPS(8), .BPM_W(8)) sif ();
    step_sequencer_if #(.NUM_CH(3), .NUM_STEPS(6), .BPM_W(8)) sif2 ();

    step_sequencer #(
        .NUM_CH(4), .NUM_STEPS(8), .CLK_HZ(64'd100), .STEPS_PER_BEAT(1), .BPM_W(8), .DEFAULT_BPM(120)
    ) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (sif.slave)
    );

    step_sequencer #(
        .NUM_CH(3), .NUM_STEPS(6), .CLK_HZ(64'd100), .STEPS_PER_BEAT(1), .BPM_W(8), .DEFAULT_BPM(120)
    ) dut2 (
        .clk   (clk),
        .reset (rst),
        .bus   (sif2.slave)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: wait bound expired, got no event, expected one", name);
    endtask

    function automatic logic [NCH-1:0] m_col(input int s);
        logic [NCH-1:0] r;
        for (int c = 0; c < NCH; c++) r[c] = m_pat[c][s];
        return r;
    endfunction

    function automatic bit fire_pending();
        return m_playing && (m_acc + longint'(m_bpm * SPB) >= LIM);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++)
            for (int s = 0; s < NST; s++) m_pat[c][s] = 1'b0;
        m_step = 0;
        m_bpm = 120;
        m_acc = 0;
        m_playing = 1'b0;
        sb_q.delete();
    endtask

    task automatic push_exp(input int s);
        exp_t e;
        e.cyc  = cyc + 1;
        e.step = s;
        e.trig = m_col(s) & ~sif.mute;
        sb_q.push_back(e);
    endtask

    // Applies the sequencer rules to the inputs present this cycle.
    task automatic model_cycle();
        bit fire;
        int eff;
        if (rst) begin
            model_reset();
            return;
        end
        fire = 1'b0;
        if (m_playing && !sif.start && !sif.stop) begin
            if (m_acc + longint'(m_bpm * SPB) >= LIM) begin
                fire = 1'b1;
                m_acc = m_acc + longint'(m_bpm * SPB) - LIM;
            end else begin
                m_acc = m_acc + longint'(m_bpm * SPB);
            end
        end
        if (sif.stop) begin
            m_playing = 1'b0;
            m_step = 0;
            m_acc = 0;
        end else if (sif.start) begin
            m_playing = 1'b1;
            m_step = 0;
            m_acc = 0;
            push_exp(0);
        end else if (fire) begin
            eff = (int'(sif.loop_len) > NST - 1) ? NST - 1 : int'(sif.loop_len);
            m_step = (m_step >= eff) ? 0 : m_step + 1;
            push_exp(m_step);
        end
        if (sif.wr_en && int'(sif.wr_ch) < NCH && int'(sif.wr_step) < NST)
            m_pat[sif.wr_ch][sif.wr_step] = sif.wr_val;
        if (sif.bpm_load) m_bpm = int'(sif.bpm);
    endtask

    task automatic clk_cycle();
        model_cycle();
        @(negedge clk);
        sif.start = 1'b0;
        sif.stop = 1'b0;
        sif.bpm_load = 1'b0;
        sif.wr_en = 1'b0;
    endtask

    task automatic write_cell(input int ch, input int st, input bit v);
        sif.wr_en = 1'b1;
        sif.wr_ch = 2'(ch);
        sif.wr_step = 3'(st);
        sif.wr_val = v;
        clk_cycle();
    endtask

    // Monitor: pops an expectation on every step pulse and checks steady-state outputs.
    always @(posedge clk) begin
        #1;
        if (sif.step_tick === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_tick", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                check("tick_cycle", cyc, mon_e.cyc);
                check("tick_step", sif.step_idx, mon_e.step);
                check("tick_trig", sif.trig, mon_e.trig);
            end
        end else begin
            check("quiet_trig", sif.trig, 0);
            if (sb_q.size() != 0 && sb_q[0].cyc <= cyc) begin
                mon_e = sb_q.pop_front();
                check("missing_tick", sif.step_tick, 1);
            end
        end
        check("step_idx", sif.step_idx, m_step);
        check("playing", sif.playing, m_playing);
        check("cur_col", sif.cur_col, m_col(m_step));
    end

    initial begin
        int n;
        int r;
        sif.bpm = 8'd120;
        sif.bpm_load = 1'b0;
        sif.start = 1'b0;
        sif.stop = 1'b0;
        sif.wr_en = 1'b0;
        sif.wr_ch = '0;
        sif.wr_step = '0;
        sif.wr_val = 1'b0;
        sif.loop_len = 3'd7;
        sif.mute = '0;
        sif2.bpm = '0;
        sif2.bpm_load = 1'b0;
        sif2.start = 1'b0;
        sif2.stop = 1'b0;
        sif2.wr_en = 1'b0;
        sif2.wr_ch = '0;
        sif2.wr_step = '0;
        sif2.wr_val = 1'b0;
        sif2.loop_len = 3'd5;
        sif2.mute = '0;
        model_reset();
        rst = 1'b1;
        repeat (3) clk_cycle();
        rst = 1'b0;

        // Three-channel grid: channel code 3 is out of range and must be dropped.
        sif2.wr_en = 1'b1; sif2.wr_ch = 2'd3; sif2.wr_step = 3'd0; sif2.wr_val = 1'b1;
        clk_cycle();
        sif2.wr_en = 1'b0;
        check("oor_ch_ignored", sif2.cur_col, 3'b000);
        sif2.wr_en = 1'b1; sif2.wr_ch = 2'd2; sif2.wr_step = 3'd0; sif2.wr_val = 1'b1;
        clk_cycle();
        sif2.wr_en = 1'b0;
        check("inrange_ch_written", sif2.cur_col, 3'b100);

        // Basic playback at 120 bpm with hits on steps 0 and 4, full 8-step loop.
        sif.bpm = 8'd120; sif.bpm_load = 1'b1;
        clk_cycle();
        write_cell(0, 0, 1'b1);
        write_cell(0, 4, 1'b1);
        sif.loop_len = 3'd7;
        sif.start = 1'b1;
        clk_cycle();
        repeat (450) clk_cycle();

        // Shorten the loop while past its new end.
        n = 0;
        while (m_step != 5 && n < 1000) begin clk_cycle(); n++; end
        if (n >= 1000) timeout_fail("reach_step5");
        sif.loop_len = 3'd2;
        repeat (300) clk_cycle();

        // Mute channel 0, then release it.
        sif.mute = 4'b0001;
        repeat (400) clk_cycle();
        sif.mute = 4'b0000;
        repeat (400) clk_cycle();

        // Live tempo change mid-step with the phase at half a step.
        sif.loop_len = 3'd7;
        n = 0;
        while (!(m_playing && m_acc == 3000) && n < 1000) begin clk_cycle(); n++; end
        if (n >= 1000) timeout_fail("reach_acc3000");
        sif.bpm = 8'd240; sif.bpm_load = 1'b1;
        clk_cycle();
        repeat (200) clk_cycle();

        // Simultaneous start/stop, stop on a fire decision, then a zero tempo.
        sif.start = 1'b1; sif.stop = 1'b1;
        clk_cycle();
        repeat (20) clk_cycle();
        sif.start = 1'b1;
        clk_cycle();
        n = 0;
        while (!fire_pending() && n < 500) begin clk_cycle(); n++; end
        if (n >= 500) timeout_fail("reach_fire_for_stop");
        sif.stop = 1'b1;
        clk_cycle();
        repeat (10) clk_cycle();
        sif.bpm = 8'd0; sif.bpm_load = 1'b1;
        clk_cycle();
        sif.start = 1'b1;
        clk_cycle();
        repeat (1000) clk_cycle();
        sif.stop = 1'b1;
        clk_cycle();

        // Write the upcoming step's cell on the fire-decision cycle.
        sif.bpm = 8'd120; sif.bpm_load = 1'b1;
        clk_cycle();
        sif.start = 1'b1;
        clk_cycle();
        n = 0;
        while (!(m_step == 2 && fire_pending()) && n < 1000) begin clk_cycle(); n++; end
        if (n >= 1000) timeout_fail("reach_fire_at_step2");
        write_cell(1, 3, 1'b1);
        repeat (450) clk_cycle();

        // Random traffic, including occasional mid-play reset.
        for (int i = 0; i < 2500; i++) begin
            r = int'($urandom_range(0, 999));
            sif.start = (r < 8);
            sif.stop = (r >= 8 && r < 12);
            if ($urandom_range(0, 99) < 3) begin
                sif.bpm_load = 1'b1;
                sif.bpm = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(150, 255));
            end
            if ($urandom_range(0, 3) == 0) begin
                sif.wr_en = 1'b1;
                sif.wr_ch = 2'($urandom);
                sif.wr_step = 3'($urandom);
                sif.wr_val = 1'($urandom);
            end
            if ($urandom_range(0, 49) == 0) sif.loop_len = 3'($urandom);
            if ($urandom_range(0, 49) == 0) sif.mute = 4'($urandom);
            rst = ($urandom_range(0, 1999) == 0);
            clk_cycle();
        end
        rst = 1'b0;
        sif.stop = 1'b1;
        clk_cycle();
        repeat (5) clk_cycle();
        check("scoreboard_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
